// File: rtl/user_func_requester_pkg.sv
// Shared constants and types for the user/function request sequencer.
// The bench imports the same package for its defaults and state names.
package user_func_requester_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_RESULT = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int CODE_W          = 3;
  localparam int CNT_W           = 3;
  localparam int TIMER_W         = 8;
  localparam int DEF_LOCK_LIMIT  = 3;
  localparam int DEF_LOCK_CYCLES = 16;

endpackage

// File: rtl/user_func_requester_if.sv
// Request, validator and result signals of the requester, with a master side
// (requester plus validator) and a slave side (the sequencer itself).
interface user_func_requester_if;
  import user_func_requester_pkg::*;

  logic              req;
  logic [CODE_W-1:0] req_user;
  logic [CODE_W-1:0] req_func;
  logic [CODE_W-1:0] chk_user;
  logic [CODE_W-1:0] chk_func;
  logic              chk_valid;
  logic              busy;
  logic              grant;
  logic              deny;
  logic [CODE_W-1:0] exec_func;
  logic              locked;

  modport master (
    output req, req_user, req_func, chk_valid,
    input  chk_user, chk_func, busy, grant, deny, exec_func, locked
  );

  modport slave (
    input  req, req_user, req_func, chk_valid,
    output chk_user, chk_func, busy, grant, deny, exec_func, locked
  );

endinterface

// File: rtl/user_func_requester_lockout_timer.sv
// Lockout countdown: loads the lockout length, counts down while enabled and
// flags the edge on which it reaches zero.
module lockout_timer
  import user_func_requester_pkg::*;
#(
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic done
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOCK_CYCLES[TIMER_W-1:0];
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Asserted in the last lockout cycle, so the owner leaves on the same edge
  // that takes the count to zero.
  assign done = enable && (count == TIMER_W'(1));

endmodule

// File: rtl/user_func_requester.sv
// Request sequencer: captures a user/function pair, asks the external validator,
// pulses grant or deny, and locks out after repeated denials.
module user_func_requester
  import user_func_requester_pkg::*;
#(
  parameter int LOCK_LIMIT  = DEF_LOCK_LIMIT,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  user_func_requester_if.slave  bus
);

  localparam logic [CNT_W-1:0] LIMIT = LOCK_LIMIT[CNT_W-1:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t            state, state_next;
  logic [CODE_W-1:0] hold_user, hold_func;
  logic              verdict;
  logic [CNT_W-1:0]  deny_cnt;
  logic [CNT_W-1:0]  deny_cnt_inc;
  logic              grant_d, deny_d;
  logic              grant_q, deny_q;
  logic [CODE_W-1:0] exec_q;
  logic              timer_load, timer_en, timer_done;

  assign deny_cnt_inc = sat_inc(deny_cnt);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (bus.req) state_next = ST_CHECK;
      ST_CHECK:  state_next = ST_RESULT;
      ST_RESULT: begin
        if (!verdict && (deny_cnt_inc == LIMIT)) state_next = ST_LOCKED;
        else                                     state_next = ST_IDLE;
      end
      ST_LOCKED: if (timer_done) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d    = 1'b0;
    deny_d     = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state)
      ST_RESULT: begin
        grant_d    = verdict;
        deny_d     = !verdict;
        timer_load = (state_next == ST_LOCKED);
      end
      ST_LOCKED: timer_en = 1'b1;
      default: ;
    endcase
  end

  // Capture, verdict sampling and the registered result pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_user <= '0;
      hold_func <= '0;
      verdict   <= 1'b0;
      deny_cnt  <= '0;
      grant_q   <= 1'b0;
      deny_q    <= 1'b0;
      exec_q    <= '0;
    end else begin
      grant_q <= grant_d;
      deny_q  <= deny_d;
      exec_q  <= grant_d ? hold_func : '0;
      if ((state == ST_IDLE) && bus.req) begin
        hold_user <= bus.req_user;
        hold_func <= bus.req_func;
      end
      if (state == ST_CHECK) verdict <= bus.chk_valid;
      if (state == ST_RESULT) begin
        deny_cnt <= verdict ? '0 : deny_cnt_inc;
      end else if (timer_done) begin
        deny_cnt <= '0;
      end
    end
  end

  lockout_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .enable (timer_en),
    .done   (timer_done)
  );

  assign bus.chk_user  = hold_user;
  assign bus.chk_func  = hold_func;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.locked    = (state == ST_LOCKED);
  assign bus.grant     = grant_q;
  assign bus.deny      = deny_q;
  assign bus.exec_func = exec_q;

endmodule

// File: doc/user_func_requester.md
USER_FUNC_REQUESTER -- requirements
Module: user_func_requester

Interface
REQ-001 Parameter LOCK_LIMIT, default 3, is the number of consecutive denials that triggers lockout (range 1..7).
REQ-002 Parameter LOCK_CYCLES, default 16, is the lockout duration in clock cycles (range 1..255).
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  is the reset: synchronous, active-high.
REQ-005 Port req  input  1  is the request strobe, sampled only in IDLE.
REQ-006 Port req_user  input  3  is the requesting user code, captured with req.
REQ-007 Port req_func  input  3  is the requested function code, captured with req.
REQ-008 Port chk_user  output  3  drives the captured user code to the external validator.
REQ-009 Port chk_func  output  3  drives the captured function code to the external validator.
REQ-010 Port chk_valid  input  1  is the validator's combinational verdict for chk_user/chk_func.
REQ-011 Port busy  output  1  is high whenever a new req is not accepted.
REQ-012 Port grant  output  1  is a one-cycle pulse for an approved request.
REQ-013 Port deny  output  1  is a one-cycle pulse for a rejected request.
REQ-014 Port exec_func  output  3  carries the approved function code; valid only while grant=1, else 3'b000.
REQ-015 Port locked  output  1  is high while in lockout.

Function
REQ-016 FSM states: IDLE, CHECK, RESULT, LOCKED.
REQ-017 IDLE: if req=1, capture req_user/req_func into holding registers and go to CHECK; else stay.
REQ-018 CHECK: chk_user/chk_func are stable from the holding registers for one full cycle; chk_valid is sampled at the end of CHECK; go to RESULT.
REQ-019 RESULT: grant=1 if the sample was 1, else deny=1; exactly one of grant/deny is high; never both.
REQ-020 Latency: req sampled at edge N -> grant/deny high during the cycle after edge N+2 (two-cycle latency).
REQ-021 The 3-bit deny counter increments on each deny, saturates at 7, and clears to 0 on each grant.
REQ-022 If a deny brings the counter to LOCK_LIMIT, RESULT goes to LOCKED; otherwise RESULT goes to IDLE.
REQ-023 LOCKED: locked=1; the timer loads LOCK_CYCLES on entry and decrements each cycle. When the timer reaches 0, go to IDLE and clear the deny counter; LOCKED lasts exactly LOCK_CYCLES cycles.
REQ-024 busy=1 in CHECK, RESULT and LOCKED; busy=0 in IDLE only.
REQ-025 req and req_user/req_func are ignored when not in IDLE; holding registers do not change.
REQ-026 chk_user/chk_func hold their last captured value outside CHECK and do not glitch-change except on capture.
REQ-027 A req asserted in the same cycle the FSM returns to IDLE is not accepted; acceptance requires being in IDLE at the sampling edge.

Reset
REQ-028 Reset=1 at a rising edge forces IDLE and overrides every other event, including mid-CHECK, mid-RESULT and mid-LOCKED.
REQ-029 Reset values: busy=0, grant=0, deny=0, locked=0, exec_func=3'b000, chk_user=3'b000, chk_func=3'b000, deny counter=0, timer=0.
REQ-030 A request interrupted by reset produces neither grant nor deny.

Structure
REQ-031 State encoding and the defaults for LOCK_LIMIT/LOCK_CYCLES are defined in the shared constants include used by the block's bench.
REQ-032 The lockout countdown is a sub-module, lockout_timer, with load, enable, and a done flag.
REQ-033 The validator is external; this block contains no user/function decoding logic.

Verification
REQ-034 Bench uses a validator model in which user=3'b001/func=3'b001 and user=3'b110/func=3'b001 are valid, and user=3'b000/func=3'b000 and user=3'b110/func=3'b000 are invalid.
REQ-035 req with user=001, func=001 at edge N -> grant=1 and exec_func=001 in cycle N+2; deny=0; busy=1 for 2 cycles.
REQ-036 req with user=000, func=000 -> deny=1 in cycle N+2; exec_func=000; deny counter=1.
REQ-037 Three consecutive invalid reqs (LOCK_LIMIT=3) -> after the third deny, locked=1 for exactly 16 cycles, then IDLE. The next valid req is granted.
REQ-038 Two denies, then a grant (user=110, func=001), then two denies -> no lockout; the counter reads 2.
REQ-039 Reset asserted during CHECK -> no grant/deny pulse; all outputs at reset values on the next cycle. req held high during RESULT/LOCKED is not accepted.
